// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
// Holds the mode encoding and the index-to-one-hot helper.
package decoder_pkg;

   typedef enum logic [1:0] {
      MODE_LEVEL = 2'd0,
      MODE_PULSE = 2'd1,
      MODE_SCAN  = 2'd2,
      MODE_OFF   = 2'd3
   } mode_t;

   // Widest select bus the helper can produce (N_BITS up to 8).
   localparam int unsigned ONEHOT_MAX_W = 256;

   // Zero-extended 1 << idx; callers keep the low 2**N_BITS bits.
   function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx);
      logic [ONEHOT_MAX_W-1:0] r;
      r = '0;
      if (idx < ONEHOT_MAX_W)
         r = ONEHOT_MAX_W'(1) << idx;
      return r;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter shared by the pulse and scan paths of decoder_strobe.
// Counts enabled cycles and flags the cycle in which cnt reaches dwell.
module dwell_timer #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               run,
   input  logic               clear,
   input  logic [DWELL_W-1:0] dwell,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt;

   // dwell is compared live; a count already past a lowered dwell simply wraps.
   assign expire = run & (cnt == dwell);

   always_ff @(posedge clk) begin
      if (!reset_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (run)
         cnt <= expire ? '0 : cnt + DWELL_W'(1);
   end

endmodule

// File: rtl/decoder_strobe.sv
// Registered binary-to-one-hot decoder with level, pulse and scan modes.
// All outputs come straight from flops; inputs only feed next-state logic.
module decoder_strobe
   import decoder_pkg::*;
#(
   parameter int unsigned N_BITS  = 3,
   parameter int unsigned DWELL_W = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  mode_t                mode,
   input  logic                 load,
   input  logic [N_BITS-1:0]    n,
   input  logic [DWELL_W-1:0]   dwell,
   output logic [2**N_BITS-1:0] decoded,
   output logic [N_BITS-1:0]    index,
   output logic                 busy
);

   localparam int unsigned OUT_W = 2**N_BITS;

   logic [N_BITS-1:0]       idx, idx_nxt;
   logic                    act, act_nxt;
   mode_t                   mode_q;
   logic                    mode_chg;
   logic                    run, clear, expire;
   logic [OUT_W-1:0]        dec_nxt;
   logic [ONEHOT_MAX_W-1:0] oh_full;

   // Timer is held at zero outside the timed modes and restarts on load or mode change.
   always_comb begin
      mode_chg = (mode != mode_q);
      clear    = load | mode_chg | (mode == MODE_LEVEL) | (mode == MODE_OFF);
      run      = enable & ~clear &
                 ((mode == MODE_SCAN) | ((mode == MODE_PULSE) & act));
   end

   dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (run),
      .clear   (clear),
      .dwell   (dwell),
      .expire  (expire)
   );

   always_comb begin
      idx_nxt = idx;
      if (load)
         idx_nxt = n;
      else if (expire && (mode == MODE_SCAN))
         idx_nxt = idx + N_BITS'(1);

      act_nxt = act;
      if (mode != MODE_PULSE)
         act_nxt = 1'b0;
      else if (load)
         act_nxt = 1'b1;
      else if (mode_chg || expire)
         act_nxt = 1'b0;
   end

   // Output is decoded from the next index so a load shows after a single edge.
   always_comb begin
      oh_full = onehot(int'(idx_nxt));
      dec_nxt = '0;
      if (enable) begin
         case (mode)
            MODE_LEVEL, MODE_SCAN: dec_nxt = oh_full[OUT_W-1:0];
            MODE_PULSE:            if (act_nxt) dec_nxt = oh_full[OUT_W-1:0];
            default:               dec_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx     <= '0;
         act     <= 1'b0;
         decoded <= '0;
         mode_q  <= mode;
      end else begin
         idx     <= idx_nxt;
         act     <= act_nxt;
         decoded <= dec_nxt;
         mode_q  <= mode;
      end
   end

   assign index = idx;
   assign busy  = act;

endmodule

// File: tb/tb_decoder_strobe.sv
// Scoreboard bench for decoder_strobe: directed stimulus pushes expected outputs,
// a monitor pops them one cycle later and compares against three instances.
module tb_decoder_strobe;
   import decoder_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en, ld;
   mode_t       md;
   logic [4:0]  nv;
   logic [7:0]  dw;

   logic [7:0]  d3;
   logic [2:0]  i3;
   logic        b3;
   logic [1:0]  d1;
   logic [0:0]  i1;
   logic        b1;
   logic [31:0] d5;
   logic [4:0]  i5;
   logic        b5;

   decoder_strobe #(.N_BITS(3), .DWELL_W(8)) u3 (
      .clk(clk), .reset_n(rst_n), .enable(en), .mode(md), .load(ld),
      .n(nv[2:0]), .dwell(dw), .decoded(d3), .index(i3), .busy(b3));

   decoder_strobe #(.N_BITS(1), .DWELL_W(4)) u1 (
      .clk(clk), .reset_n(rst_n), .enable(en), .mode(md), .load(ld),
      .n(nv[0:0]), .dwell(dw[3:0]), .decoded(d1), .index(i1), .busy(b1));

   decoder_strobe #(.N_BITS(5), .DWELL_W(4)) u5 (
      .clk(clk), .reset_n(rst_n), .enable(en), .mode(md), .load(ld),
      .n(nv), .dwell(dw[3:0]), .decoded(d5), .index(i5), .busy(b5));

   typedef struct {
      int          sel;
      logic [31:0] dec;
      logic [4:0]  idx;
      logic        busy;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic drive(input logic r, input logic e, input mode_t m, input logic l,
                        input logic [4:0] n_i, input logic [7:0] d_i);
      @(negedge clk);
      rst_n = r; en = e; md = m; ld = l; nv = n_i; dw = d_i;
   endtask

   task automatic push(input int sel, input logic [31:0] dec, input logic [4:0] idx,
                       input logic busy, input string name);
      exp_t e;
      e.sel = sel; e.dec = dec; e.idx = idx; e.busy = busy; e.name = name;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
               0: begin
                  chk({e.name, " decoded"}, {24'b0, d3}, e.dec);
                  chk({e.name, " index"},   {29'b0, i3}, {27'b0, e.idx});
                  chk({e.name, " busy"},    {31'b0, b3}, {31'b0, e.busy});
                  chk({e.name, " onehot"},  ($countones(d3) <= 1) ? 32'd1 : 32'd0, 32'd1);
               end
               1: begin
                  chk({e.name, " n1 decoded"}, {30'b0, d1}, e.dec);
                  chk({e.name, " n1 index"},   {31'b0, i1}, {27'b0, e.idx});
                  chk({e.name, " n1 busy"},    {31'b0, b1}, {31'b0, e.busy});
               end
               default: begin
                  chk({e.name, " n5 decoded"}, d5, e.dec);
                  chk({e.name, " n5 index"},   {27'b0, i5}, {27'b0, e.idx});
                  chk({e.name, " n5 busy"},    {31'b0, b5}, {31'b0, e.busy});
                  chk({e.name, " n5 onehot"},  ($countones(d5) <= 1) ? 32'd1 : 32'd0, 32'd1);
               end
            endcase
         end
      end
   end

   initial begin : stimulus
      logic [7:0] sdec [8];
      logic [2:0] sidx [8];
      int unsigned k5, k1;
      sdec = '{8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02, 8'h02, 8'h04};
      sidx = '{3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2};

      rst_n = 1'b0; en = 1'b1; md = MODE_LEVEL; ld = 1'b1; nv = 5'd5; dw = 8'd0;

      // reset dominates a pending load
      repeat (2) begin
         drive(0, 1, MODE_LEVEL, 1, 5, 0); push(0, 32'h00, 0, 0, "reset");
      end
      drive(1, 1, MODE_LEVEL, 1, 5, 0); push(0, 32'h20, 5, 0, "level load");
      repeat (4) begin
         drive(1, 1, MODE_LEVEL, 0, 1, 0); push(0, 32'h20, 5, 0, "level hold");
      end

      // pulse, dwell 3
      drive(1, 1, MODE_PULSE, 0, 1, 3); push(0, 32'h00, 5, 0, "pulse idle");
      drive(1, 1, MODE_PULSE, 1, 2, 3); push(0, 32'h04, 2, 1, "pulse start");
      repeat (3) begin
         drive(1, 1, MODE_PULSE, 0, 2, 3); push(0, 32'h04, 2, 1, "pulse high");
      end
      drive(1, 1, MODE_PULSE, 0, 2, 3); push(0, 32'h00, 2, 0, "pulse end");
      drive(1, 1, MODE_PULSE, 0, 2, 3); push(0, 32'h00, 2, 0, "pulse after");

      // retrigger during the third high cycle
      drive(1, 1, MODE_PULSE, 1, 2, 3); push(0, 32'h04, 2, 1, "retrig first");
      repeat (2) begin
         drive(1, 1, MODE_PULSE, 0, 2, 3); push(0, 32'h04, 2, 1, "retrig first high");
      end
      drive(1, 1, MODE_PULSE, 1, 6, 3); push(0, 32'h40, 6, 1, "retrig load");
      repeat (3) begin
         drive(1, 1, MODE_PULSE, 0, 6, 3); push(0, 32'h40, 6, 1, "retrig high");
      end
      drive(1, 1, MODE_PULSE, 0, 6, 3); push(0, 32'h00, 6, 0, "retrig end");

      // pulse dwell 4 with a three-cycle enable gap
      drive(1, 1, MODE_PULSE, 1, 3, 4); push(0, 32'h08, 3, 1, "gap start");
      drive(1, 1, MODE_PULSE, 0, 3, 4); push(0, 32'h08, 3, 1, "gap pre");
      repeat (3) begin
         drive(1, 0, MODE_PULSE, 0, 3, 4); push(0, 32'h00, 3, 1, "gap off");
      end
      repeat (3) begin
         drive(1, 1, MODE_PULSE, 0, 3, 4); push(0, 32'h08, 3, 1, "gap resume");
      end
      drive(1, 1, MODE_PULSE, 0, 3, 4); push(0, 32'h00, 3, 0, "gap end");

      // scan, dwell 1, across the 7->0 wrap
      drive(1, 1, MODE_SCAN, 0, 3, 1); push(0, 32'h08, 3, 0, "scan entry");
      drive(1, 1, MODE_SCAN, 1, 6, 1); push(0, 32'h40, 6, 0, "scan load");
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, MODE_SCAN, 0, 0, 1); push(0, {24'b0, sdec[i]}, {2'b0, sidx[i]}, 0, "scan seq");
      end

      // OFF keeps idx, LEVEL shows it again
      repeat (2) begin
         drive(1, 1, MODE_OFF, 0, 0, 1); push(0, 32'h00, 2, 0, "off");
      end
      drive(1, 1, MODE_LEVEL, 0, 0, 1); push(0, 32'h04, 2, 0, "off to level");

      // reset in the middle of a sweep
      drive(1, 1, MODE_SCAN, 0, 0, 1); push(0, 32'h04, 2, 0, "rescan entry");
      drive(1, 1, MODE_SCAN, 0, 0, 1); push(0, 32'h04, 2, 0, "rescan hold");
      drive(1, 1, MODE_SCAN, 0, 0, 1); push(0, 32'h08, 3, 0, "rescan step");
      drive(0, 1, MODE_SCAN, 0, 0, 1); push(0, 32'h00, 0, 0, "reset mid sweep");
      drive(1, 1, MODE_SCAN, 0, 0, 1); push(0, 32'h01, 0, 0, "post reset scan");
      drive(1, 1, MODE_SCAN, 0, 0, 1); push(0, 32'h02, 1, 0, "post reset step");

      // enable and load-while-disabled in LEVEL
      drive(1, 1, MODE_LEVEL, 0, 0, 1); push(0, 32'h02, 1, 0, "level entry");
      drive(1, 0, MODE_LEVEL, 0, 0, 1); push(0, 32'h00, 1, 0, "level disabled");
      drive(1, 1, MODE_LEVEL, 0, 0, 1); push(0, 32'h02, 1, 0, "level reenabled");
      drive(1, 0, MODE_LEVEL, 1, 7, 1); push(0, 32'h00, 7, 0, "load disabled");
      drive(1, 1, MODE_LEVEL, 0, 7, 1); push(0, 32'h80, 7, 0, "load shown");

      // boundary widths, scan with dwell 0
      drive(0, 1, MODE_SCAN, 0, 0, 0);
      push(1, 32'h0, 0, 0, "bnd reset");
      push(2, 32'h0, 0, 0, "bnd reset");
      drive(1, 1, MODE_SCAN, 1, 30, 0);
      push(1, 32'h1, 0, 0, "bnd load");
      push(2, 32'h4000_0000, 30, 0, "bnd load");
      for (int unsigned k = 1; k <= 5; k++) begin
         drive(1, 1, MODE_SCAN, 0, 0, 0);
         k5 = (30 + k) % 32;
         k1 = k % 2;
         push(1, 32'(1) << k1, 5'(k1), 0, "bnd dwell0");
         push(2, 32'(1) << k5, 5'(k5), 0, "bnd dwell0");
      end

      // maximum dwell on a 4-bit timer holds each output 16 cycles
      drive(1, 1, MODE_SCAN, 1, 4, 15); push(2, 32'h10, 4, 0, "dwell max load");
      repeat (15) begin
         drive(1, 1, MODE_SCAN, 0, 4, 15); push(2, 32'h10, 4, 0, "dwell max hold");
      end
      drive(1, 1, MODE_SCAN, 0, 4, 15); push(2, 32'h20, 5, 0, "dwell max advance");

      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
